// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with bounded-burst ownership and one-cycle read return.
// Define DMEM_ARB_STATS_EN to build the grant/stall statistics counters.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [2:0]  a_funct3,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [2:0]  b_funct3,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        dmem_wren,
    output logic [2:0]  dmem_funct3,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_data_in,
    input  logic [31:0] dmem_data_out,
    output logic [31:0] a_grant_cnt,
    output logic [31:0] b_grant_cnt,
    output logic [31:0] a_stall_cnt,
    output logic [1:0]  dbg_owner
);

    // Handshake: a requester holds req and its fields stable until gnt; gnt means the
    // access is issued this cycle; a granted load returns rvalid/rdata exactly one cycle later.

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    owner_t          owner_q;
    owner_t          winner;
    owner_t          rd_tag_q;
    owner_t          rd_tag_d;
    logic [CW-1:0]   burst_q;
    logic [CW-1:0]   burst_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            burst_q  <= '0;
            rd_tag_q <= OWN_NONE;
        end else begin
            owner_q  <= winner;
            burst_q  <= burst_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    // The owner keeps winning under contention until it has used MAX_BURST grants.
    always_comb begin
        winner   = OWN_NONE;
        burst_d  = '0;
        rd_tag_d = OWN_NONE;
        if (a_req && b_req) begin
            case (owner_q)
                OWN_A:   winner = (burst_q < BURST_MAX) ? OWN_A : OWN_B;
                OWN_B:   winner = (burst_q < BURST_MAX) ? OWN_B : OWN_A;
                default: winner = OWN_A;
            endcase
        end else if (a_req) begin
            winner = OWN_A;
        end else if (b_req) begin
            winner = OWN_B;
        end

        if (winner == OWN_NONE) begin
            burst_d = '0;
        end else if (winner == owner_q) begin
            burst_d = (burst_q < BURST_MAX) ? burst_q + CW'(1) : burst_q;
        end else begin
            burst_d = CW'(1);
        end

        if (winner == OWN_A && !a_we) begin
            rd_tag_d = OWN_A;
        end else if (winner == OWN_B && !b_we) begin
            rd_tag_d = OWN_B;
        end
    end

    always_comb begin
        dmem_wren    = 1'b0;
        dmem_funct3  = 3'd0;
        dmem_address = 32'd0;
        dmem_data_in = 32'd0;
        case (winner)
            OWN_A: begin
                dmem_wren    = a_we;
                dmem_funct3  = a_funct3;
                dmem_address = a_addr;
                dmem_data_in = a_wdata;
            end
            OWN_B: begin
                dmem_wren    = b_we;
                dmem_funct3  = b_funct3;
                dmem_address = b_addr;
                dmem_data_in = b_wdata;
            end
            default: ;
        endcase
    end

    assign a_gnt = (winner == OWN_A);
    assign b_gnt = (winner == OWN_B);

    // Reset in the response cycle drops the in-flight read.
    assign a_rvalid  = (rd_tag_q == OWN_A) && !reset;
    assign b_rvalid  = (rd_tag_q == OWN_B) && !reset;
    assign a_rdata   = a_rvalid ? dmem_data_out : 32'd0;
    assign b_rdata   = b_rvalid ? dmem_data_out : 32'd0;
    assign dbg_owner = owner_q;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] a_grant_q;
    logic [31:0] b_grant_q;
    logic [31:0] a_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_grant_q <= 32'd0;
            b_grant_q <= 32'd0;
            a_stall_q <= 32'd0;
        end else begin
            if (a_gnt)
                a_grant_q <= a_grant_q + 32'd1;
            if (b_gnt)
                b_grant_q <= b_grant_q + 32'd1;
            if (a_req && !a_gnt)
                a_stall_q <= a_stall_q + 32'd1;
        end
    end

    assign a_grant_cnt = a_grant_q;
    assign b_grant_cnt = b_grant_q;
    assign a_stall_cnt = a_stall_q;
`else
    assign a_grant_cnt = 32'd0;
    assign b_grant_cnt = 32'd0;
    assign a_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: MAX_BURST=4 instance for most steps, MAX_BURST=1 for alternation.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        a_req, b_req, a_we, b_we;
    logic [2:0]  a_funct3, b_funct3;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        dmem_wren;
    logic [2:0]  dmem_funct3;
    logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
    logic [31:0] a_grant_cnt, b_grant_cnt, a_stall_cnt;
    logic [1:0]  dbg_owner;

    logic        m1_a_req, m1_b_req;
    logic [31:0] m1_a_addr, m1_b_addr;
    logic        m1_a_gnt, m1_b_gnt, m1_a_rvalid, m1_b_rvalid;
    logic [31:0] m1_a_rdata, m1_b_rdata;
    logic        m1_dmem_wren;
    logic [2:0]  m1_dmem_funct3;
    logic [31:0] m1_dmem_address, m1_dmem_data_in, m1_dmem_data_out;
    logic [31:0] m1_a_grant_cnt, m1_b_grant_cnt, m1_a_stall_cnt;
    logic [1:0]  m1_dbg_owner;

    int n_checks = 0;
    int n_errs   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_q1[$];

    dmem_arbiter #(.MAX_BURST(4)) u_dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_funct3(b_funct3), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .dmem_wren(dmem_wren), .dmem_funct3(dmem_funct3), .dmem_address(dmem_address),
        .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
        .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt), .a_stall_cnt(a_stall_cnt),
        .dbg_owner(dbg_owner)
    );

    dmem_arbiter #(.MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .a_req(m1_a_req), .a_we(1'b0), .a_funct3(3'b010), .a_addr(m1_a_addr), .a_wdata(32'd0),
        .a_gnt(m1_a_gnt), .a_rvalid(m1_a_rvalid), .a_rdata(m1_a_rdata),
        .b_req(m1_b_req), .b_we(1'b0), .b_funct3(3'b010), .b_addr(m1_b_addr), .b_wdata(32'd0),
        .b_gnt(m1_b_gnt), .b_rvalid(m1_b_rvalid), .b_rdata(m1_b_rdata),
        .dmem_wren(m1_dmem_wren), .dmem_funct3(m1_dmem_funct3), .dmem_address(m1_dmem_address),
        .dmem_data_in(m1_dmem_data_in), .dmem_data_out(m1_dmem_data_out),
        .a_grant_cnt(m1_a_grant_cnt), .b_grant_cnt(m1_b_grant_cnt), .a_stall_cnt(m1_a_stall_cnt),
        .dbg_owner(m1_dbg_owner)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // memory model: one-cycle registered read
    function automatic logic [31:0] mem_f(input logic [31:0] adr);
        return (adr == 32'h10) ? 32'hDEADBEEF : (adr ^ 32'h5A5A_0000);
    endfunction

    always_ff @(posedge clk) begin
        dmem_data_out    <= mem_f(dmem_address);
        m1_dmem_data_out <= mem_f(m1_dmem_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of load traffic on the MAX_BURST=4 instance; w: 0 none, 1 A, 2 B.
    task automatic step(input string tag, input logic ar, input logic br, input logic [1:0] w);
        logic [1:0] r;
        a_req = ar;
        b_req = br;
        #1;
        r = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
        chk($sformatf("%s.a_gnt", tag), a_gnt, w == 2'd1);
        chk($sformatf("%s.b_gnt", tag), b_gnt, w == 2'd2);
        chk($sformatf("%s.a_rvalid", tag), a_rvalid, r == 2'd1);
        chk($sformatf("%s.b_rvalid", tag), b_rvalid, r == 2'd2);
        chk($sformatf("%s.a_rdata", tag), a_rdata, (r == 2'd1) ? mem_f(a_addr) : 32'd0);
        chk($sformatf("%s.b_rdata", tag), b_rdata, (r == 2'd2) ? mem_f(b_addr) : 32'd0);
        chk($sformatf("%s.dmem_address", tag), dmem_address,
            (w == 2'd1) ? a_addr : (w == 2'd2) ? b_addr : 32'd0);
        chk($sformatf("%s.dmem_wren", tag), dmem_wren, 1'b0);
        exp_q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input string tag, input logic ar, input logic br, input logic [1:0] w);
        logic [1:0] r;
        m1_a_req = ar;
        m1_b_req = br;
        #1;
        r = (exp_q1.size() > 0) ? exp_q1.pop_front() : 2'd0;
        chk($sformatf("%s.a_gnt", tag), m1_a_gnt, w == 2'd1);
        chk($sformatf("%s.b_gnt", tag), m1_b_gnt, w == 2'd2);
        chk($sformatf("%s.a_rvalid", tag), m1_a_rvalid, r == 2'd1);
        chk($sformatf("%s.b_rvalid", tag), m1_b_rvalid, r == 2'd2);
        chk($sformatf("%s.a_rdata", tag), m1_a_rdata, (r == 2'd1) ? mem_f(m1_a_addr) : 32'd0);
        chk($sformatf("%s.b_rdata", tag), m1_b_rdata, (r == 2'd2) ? mem_f(m1_b_addr) : 32'd0);
        exp_q1.push_back(w);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_funct3 = 3'b010; b_funct3 = 3'b010;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        m1_a_req = 0; m1_b_req = 0; m1_a_addr = 32'h300; m1_b_addr = 32'h400;

        // reset state
        repeat (2) tick();
        chk("rst.a_rvalid", a_rvalid, 1'b0);
        chk("rst.b_rvalid", b_rvalid, 1'b0);
        chk("rst.a_rdata", a_rdata, 32'd0);
        chk("rst.b_rdata", b_rdata, 32'd0);
        chk("rst.owner", dbg_owner, 2'd0);
        chk("rst.a_grant_cnt", a_grant_cnt, 32'd0);
        chk("rst.a_stall_cnt", a_stall_cnt, 32'd0);
        reset = 1'b0;

        // A-only load of 0x10
        a_req = 1; a_addr = 32'h10; a_funct3 = 3'b010; a_we = 0;
        #1;
        chk("t1.a_gnt", a_gnt, 1'b1);
        chk("t1.b_gnt", b_gnt, 1'b0);
        chk("t1.dmem_address", dmem_address, 32'h10);
        chk("t1.dmem_funct3", dmem_funct3, 3'b010);
        chk("t1.dmem_wren", dmem_wren, 1'b0);
        tick();
        a_req = 0;
        #1;
        chk("t1.a_rvalid", a_rvalid, 1'b1);
        chk("t1.a_rdata", a_rdata, 32'hDEADBEEF);
        chk("t1.b_rvalid", b_rvalid, 1'b0);
        chk("t1.dmem_address_idle", dmem_address, 32'd0);
        tick();
        chk("t1.owner_idle", dbg_owner, 2'd0);
        chk("t1.a_rvalid_gone", a_rvalid, 1'b0);

        // A load and B store collide with no owner
        a_req = 1; a_addr = 32'h20;
        b_req = 1; b_we = 1; b_funct3 = 3'b000; b_addr = 32'hFFFF_FFFC; b_wdata = 32'h0000_00AA;
        #1;
        chk("t2.a_gnt", a_gnt, 1'b1);
        chk("t2.b_gnt", b_gnt, 1'b0);
        chk("t2.dmem_wren_a", dmem_wren, 1'b0);
        chk("t2.dmem_address_a", dmem_address, 32'h20);
        tick();
        a_req = 0;
        #1;
        chk("t2.b_gnt2", b_gnt, 1'b1);
        chk("t2.dmem_wren_b", dmem_wren, 1'b1);
        chk("t2.dmem_address_b", dmem_address, 32'hFFFF_FFFC);
        chk("t2.dmem_data_in", dmem_data_in, 32'h0000_00AA);
        chk("t2.dmem_funct3", dmem_funct3, 3'b000);
        chk("t2.a_rvalid", a_rvalid, 1'b1);
        chk("t2.a_rdata", a_rdata, 32'h5A5A_0020);
        tick();
        b_req = 0; b_we = 0; b_funct3 = 3'b010; b_wdata = 0;
        #1;
        chk("t2.b_rvalid_store", b_rvalid, 1'b0);
        chk("t2.a_rvalid_after", a_rvalid, 1'b0);
        tick();

        // continuous contention from idle
        a_addr = 32'h100; b_addr = 32'h200;
        exp_q.delete();
        step("t3c0", 1, 1, 2'd1);
        step("t3c1", 1, 1, 2'd1);
        step("t3c2", 1, 1, 2'd1);
        step("t3c3", 1, 1, 2'd1);
        step("t3c4", 1, 1, 2'd2);
        step("t3c5", 1, 1, 2'd2);
        step("t3c6", 1, 1, 2'd2);
        step("t3c7", 1, 1, 2'd2);
        chk("t3.a_stall_cnt", a_stall_cnt, STATS ? 32'd4 : 32'd0);
        chk("t3.a_grant_cnt", a_grant_cnt, STATS ? 32'd6 : 32'd0);
        chk("t3.b_grant_cnt", b_grant_cnt, STATS ? 32'd5 : 32'd0);
        step("t3c8", 1, 1, 2'd1);
        step("t3c9", 0, 0, 2'd0);

        // burst hand-off, A drop/re-raise, owner dropping under contention
        step("t4c0", 1, 0, 2'd1);
        step("t4c1", 1, 0, 2'd1);
        step("t4c2", 1, 0, 2'd1);
        step("t4c3", 1, 1, 2'd1);
        step("t4c4", 1, 1, 2'd2);
        step("t4c5", 1, 1, 2'd2);
        step("t4c6", 0, 1, 2'd2);
        step("t4c7", 1, 1, 2'd2);
        step("t4c8", 1, 1, 2'd1);
        step("t4c9", 0, 1, 2'd2);
        step("t4c10", 0, 0, 2'd0);
        chk("t4.owner_idle", dbg_owner, 2'd0);

        // reset the cycle after a granted load
        a_addr = 32'h10;
        a_req = 1;
        #1;
        chk("t5.a_gnt", a_gnt, 1'b1);
        tick();
        a_req = 0;
        reset = 1;
        #1;
        chk("t5.a_rvalid", a_rvalid, 1'b0);
        chk("t5.a_rdata", a_rdata, 32'd0);
        chk("t5.b_rvalid", b_rvalid, 1'b0);
        tick();
        chk("t5.owner", dbg_owner, 2'd0);
        chk("t5.a_rvalid_post", a_rvalid, 1'b0);
        chk("t5.a_grant_cnt", a_grant_cnt, 32'd0);
        chk("t5.b_grant_cnt", b_grant_cnt, 32'd0);
        chk("t5.a_stall_cnt", a_stall_cnt, 32'd0);
        reset = 0;
        tick();

        // MAX_BURST=1 strict alternation
        exp_q1.delete();
        step1("t6c0", 1, 1, 2'd1);
        step1("t6c1", 1, 1, 2'd2);
        step1("t6c2", 1, 1, 2'd1);
        step1("t6c3", 1, 1, 2'd2);
        step1("t6c4", 0, 0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
